// File: rtl/irqctl.sv
`default_nettype none
// ============================================================================
// Module      : irqctl
// Description : Prioritised interrupt controller with a four-register uC bus
//               interface (PEND, MASK, VEC, EDGE). One request is delivered
//               to the CPU at a time. It is acknowledged by reading VEC and
//               closed by writing VEC (end-of-interrupt).
//               Optional macro IRQCTL_EDGE_EN adds the EDGE register and
//               per-source rising-edge detection. Without the macro, every
//               source is level-sensitive.
// Revision    : 1.0 - initial release
// ============================================================================
module irqctl #(
    parameter int N_SRC = 8
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic [N_SRC-1:0]  irq_src_i,
    input  logic              sel_i,
    input  logic              read_i,
    input  logic              write_i,
    input  logic [1:0]        addr_i,
    input  logic [15:0]       data_i,
    output logic [15:0]       data_o,
    output logic              irq_o
);

    localparam logic [1:0] ADDR_PEND = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_VEC  = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t           state;
    logic [N_SRC-1:0] pend;
    logic [N_SRC-1:0] pend_next;
    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] active;
    logic [3:0]       vector_q;
    logic [3:0]       prio_idx;
    logic [1:0]       addr_q;
    logic             rd_strobe;
    logic             wr_strobe;
    logic             vec_rd;
    logic             vec_wr;
    logic             unused_data;

    assign rd_strobe   = sel_i & read_i;
    assign wr_strobe   = sel_i & write_i;
    assign vec_rd      = rd_strobe && (addr_i == ADDR_VEC);
    assign vec_wr      = wr_strobe && (addr_i == ADDR_VEC);
    assign active      = pend & mask;
    assign unused_data = ^data_i;

    // Fixed priority: the lowest-numbered active source wins.
    always_comb begin
        prio_idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (active[i]) prio_idx = 4'(i);
        end
    end

`ifdef IRQCTL_EDGE_EN
    logic [N_SRC-1:0] src_q;
    logic [N_SRC-1:0] edge_sel;
    logic [N_SRC-1:0] w1c;
    logic [N_SRC-1:0] ack_clr;

    // The acknowledged source's pending bit is cleared if that source is edge-triggered.
    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < N_SRC; i++) begin
            ack_clr[i] = (state == ST_REQ) && vec_rd && (|active) && (prio_idx == 4'(i));
        end
    end

    assign w1c = (wr_strobe && (addr_i == ADDR_PEND)) ? data_i[N_SRC-1:0] : '0;

    // Edge sources: a new rising edge wins over a same-cycle clear. Level sources follow the input.
    assign pend_next = (edge_sel & ((pend & ~(w1c | ack_clr)) | (irq_src_i & ~src_q)))
                     | (~edge_sel & irq_src_i);

    // Source history for edge detection, and the EDGE configuration register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            src_q    <= '0;
            edge_sel <= '0;
        end else begin
            src_q <= irq_src_i;
            if (wr_strobe && (addr_i == ADDR_EDGE)) edge_sel <= data_i[N_SRC-1:0];
        end
    end
`else
    assign pend_next = irq_src_i;
`endif

    // Pending and mask registers, plus the latched read address.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pend   <= '0;
            mask   <= '0;
            addr_q <= ADDR_PEND;
        end else begin
            pend <= pend_next;
            if (wr_strobe && (addr_i == ADDR_MASK)) mask <= data_i[N_SRC-1:0];
            if (rd_strobe) addr_q <= addr_i;
        end
    end

    // Request/acknowledge/EOI sequencing. irq_o is high exactly while in REQ.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state    <= ST_IDLE;
            irq_o    <= 1'b0;
            vector_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|active) begin
                        state <= ST_REQ;
                        irq_o <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (vec_rd) begin
                        irq_o <= 1'b0;
                        if (|active) begin
                            vector_q <= prio_idx;
                            state    <= ST_SERVICE;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else if (!(|active)) begin
                        state <= ST_IDLE;
                        irq_o <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    if (vec_wr) state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    irq_o <= 1'b0;
                end
            endcase
        end
    end

    // Read data decodes the address captured by the previous read strobe.
    always_comb begin
        data_o = '0;
        case (addr_q)
            ADDR_PEND: data_o[N_SRC-1:0] = pend;
            ADDR_MASK: data_o[N_SRC-1:0] = mask;
            ADDR_VEC: begin
                data_o[15]  = (state == ST_SERVICE);
                data_o[3:0] = vector_q;
            end
`ifdef IRQCTL_EDGE_EN
            ADDR_EDGE: data_o[N_SRC-1:0] = edge_sel;
`endif
            default: data_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_irqctl.sv
`default_nettype none
// ============================================================================
// Module      : tb_irqctl
// Description : Directed table-driven bench for irqctl, plus a hand-written
//               asynchronous-reset sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irqctl;

    logic        clk_i;
    logic        rstn_i;
    logic [7:0]  irq_src_i;
    logic        sel_i;
    logic        read_i;
    logic        write_i;
    logic [1:0]  addr_i;
    logic [15:0] data_i;
    logic [15:0] data_o;
    logic        irq_o;

    int total = 0;
    int bad   = 0;

`ifdef IRQCTL_EDGE_EN
    localparam logic [15:0] EXP_EDGE = 16'h00FF;
`else
    localparam logic [15:0] EXP_EDGE = 16'h0000;
`endif

    localparam int OP_IDLE = 0;
    localparam int OP_RD   = 1;
    localparam int OP_WR   = 2;

    typedef struct {
        logic        rst;
        int          op;
        logic [1:0]  addr;
        logic [15:0] wdata;
        logic [7:0]  src;
        logic [15:0] exp_data;
        logic        exp_irq;
    } vec_t;

    vec_t tbl[$];

    irqctl #(.N_SRC(8)) dut (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .irq_src_i (irq_src_i),
        .sel_i     (sel_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .addr_i    (addr_i),
        .data_i    (data_i),
        .data_o    (data_o),
        .irq_o     (irq_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic void add(logic rst, int op, logic [1:0] addr, logic [15:0] wdata,
                                logic [7:0] src, logic [15:0] exp_data, logic exp_irq);
        vec_t v;
        v.rst = rst; v.op = op; v.addr = addr; v.wdata = wdata;
        v.src = src; v.exp_data = exp_data; v.exp_irq = exp_irq;
        tbl.push_back(v);
    endfunction

    task automatic drive(logic rst, int op, logic [1:0] addr, logic [15:0] wdata, logic [7:0] src);
        rstn_i    = ~rst;
        sel_i     = (op != OP_IDLE);
        read_i    = (op == OP_RD);
        write_i   = (op == OP_WR);
        addr_i    = addr;
        data_i    = wdata;
        irq_src_i = src;
    endtask

    task automatic check(string name, logic [15:0] got, logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    initial begin
        // Reset state
        drive(1'b1, OP_IDLE, 2'd0, 16'h0, 8'h00);
        repeat (2) @(posedge clk_i);
        #1;
        check("reset irq", {15'd0, irq_o}, 16'd0);
        check("reset data", data_o, 16'h0000);

        // Single source, acknowledge and EOI
        add(0, OP_WR,   2'd1, 16'h0004, 8'h00, 16'h0000, 0);
        add(0, OP_IDLE, 2'd0, 16'h0000, 8'h04, 16'h0004, 0);
        add(0, OP_IDLE, 2'd0, 16'h0000, 8'h04, 16'h0004, 1);
        add(0, OP_RD,   2'd2, 16'h0000, 8'h04, 16'h8002, 0);
        add(0, OP_IDLE, 2'd0, 16'h0000, 8'h04, 16'h8002, 0);
        add(0, OP_WR,   2'd2, 16'h0000, 8'h04, 16'h0002, 0);
        add(0, OP_IDLE, 2'd0, 16'h0000, 8'h04, 16'h0002, 1);
        add(0, OP_RD,   2'd1, 16'h0000, 8'h04, 16'h0004, 1);
        // Mask withdrawn while requesting
        add(0, OP_WR,   2'd1, 16'h0000, 8'h04, 16'h0000, 1);
        add(0, OP_IDLE, 2'd0, 16'h0000, 8'h04, 16'h0000, 0);
        // Priority between sources 5 and 3
        add(0, OP_WR,   2'd1, 16'h00FF, 8'h28, 16'h00FF, 0);
        add(0, OP_IDLE, 2'd0, 16'h0000, 8'h28, 16'h00FF, 1);
        add(0, OP_RD,   2'd2, 16'h0000, 8'h28, 16'h8003, 0);
        // New source while in service: no nesting, side-effect-free VEC read
        add(0, OP_IDLE, 2'd0, 16'h0000, 8'h2A, 16'h8003, 0);
        add(0, OP_IDLE, 2'd0, 16'h0000, 8'h2A, 16'h8003, 0);
        add(0, OP_RD,   2'd2, 16'h0000, 8'h2A, 16'h8003, 0);
        add(0, OP_WR,   2'd2, 16'h0000, 8'h2A, 16'h0003, 0);
        add(0, OP_IDLE, 2'd0, 16'h0000, 8'h2A, 16'h0003, 1);
        add(0, OP_RD,   2'd2, 16'h0000, 8'h2A, 16'h8001, 0);
        add(0, OP_WR,   2'd2, 16'h0000, 8'h2A, 16'h0001, 0);
        add(0, OP_IDLE, 2'd0, 16'h0000, 8'h00, 16'h0001, 1);
        add(0, OP_IDLE, 2'd0, 16'h0000, 8'h00, 16'h0001, 0);
        // Acknowledge read in REQ after the source vanished
        add(0, OP_IDLE, 2'd0, 16'h0000, 8'h01, 16'h0001, 0);
        add(0, OP_IDLE, 2'd0, 16'h0000, 8'h00, 16'h0001, 1);
        add(0, OP_RD,   2'd2, 16'h0000, 8'h00, 16'h0001, 0);
        // Reset in the middle of service
        add(0, OP_IDLE, 2'd0, 16'h0000, 8'h10, 16'h0001, 0);
        add(0, OP_IDLE, 2'd0, 16'h0000, 8'h10, 16'h0001, 1);
        add(0, OP_RD,   2'd2, 16'h0000, 8'h10, 16'h8004, 0);
        add(1, OP_IDLE, 2'd0, 16'h0000, 8'h10, 16'h0000, 0);
        add(0, OP_RD,   2'd1, 16'h0000, 8'h00, 16'h0000, 0);
        add(0, OP_RD,   2'd2, 16'h0000, 8'h00, 16'h0000, 0);
        // Mask withdrawn with vector never latched
        add(0, OP_WR,   2'd1, 16'h0080, 8'h80, 16'h0000, 0);
        add(0, OP_IDLE, 2'd0, 16'h0000, 8'h80, 16'h0000, 1);
        add(0, OP_WR,   2'd1, 16'h0000, 8'h80, 16'h0000, 1);
        add(0, OP_IDLE, 2'd0, 16'h0000, 8'h80, 16'h0000, 0);
        // EDGE register and unimplemented bits
        add(0, OP_WR,   2'd3, 16'hFFFF, 8'h00, 16'h0000, 0);
        add(0, OP_RD,   2'd3, 16'h0000, 8'h00, EXP_EDGE, 0);
        add(0, OP_WR,   2'd1, 16'hFFFF, 8'h00, EXP_EDGE, 0);
        add(0, OP_RD,   2'd1, 16'h0000, 8'h00, 16'h00FF, 0);
`ifdef IRQCTL_EDGE_EN
        // Edge source 0: pulse persists, ack clears, set beats W1C
        add(0, OP_WR,   2'd3, 16'h0001, 8'h00, 16'h00FF, 0);
        add(0, OP_IDLE, 2'd0, 16'h0000, 8'h01, 16'h00FF, 0);
        add(0, OP_RD,   2'd0, 16'h0000, 8'h00, 16'h0001, 1);
        add(0, OP_IDLE, 2'd0, 16'h0000, 8'h00, 16'h0001, 1);
        add(0, OP_RD,   2'd2, 16'h0000, 8'h00, 16'h8000, 0);
        add(0, OP_RD,   2'd0, 16'h0000, 8'h00, 16'h0000, 0);
        add(0, OP_WR,   2'd2, 16'h0000, 8'h00, 16'h0000, 0);
        add(0, OP_WR,   2'd0, 16'h0001, 8'h01, 16'h0001, 0);
        add(0, OP_IDLE, 2'd0, 16'h0000, 8'h01, 16'h0001, 1);
        add(0, OP_WR,   2'd0, 16'h0001, 8'h01, 16'h0000, 1);
        add(0, OP_IDLE, 2'd0, 16'h0000, 8'h01, 16'h0000, 0);
`endif

        foreach (tbl[k]) begin
            drive(tbl[k].rst, tbl[k].op, tbl[k].addr, tbl[k].wdata, tbl[k].src);
            @(posedge clk_i);
            #1;
            check($sformatf("row%0d data", k), data_o, tbl[k].exp_data);
            check($sformatf("row%0d irq", k), {15'd0, irq_o}, {15'd0, tbl[k].exp_irq});
        end

        // Asynchronous reset while a request is being raised
        drive(1'b0, OP_IDLE, 2'd0, 16'h0000, 8'h04);
        begin : wait_irq
            bit seen;
            seen = 1'b0;
            for (int c = 0; c < 6 && !seen; c++) begin
                @(posedge clk_i);
                #1;
                if (irq_o === 1'b1) seen = 1'b1;
            end
            check("irq before async reset", {15'd0, seen}, 16'd1);
        end
        #2;
        rstn_i = 1'b0;
        #1;
        check("async reset irq", {15'd0, irq_o}, 16'd0);
        check("async reset data", data_o, 16'h0000);
        @(posedge clk_i);
        #1;
        drive(1'b0, OP_RD, 2'd1, 16'h0000, 8'h00);
        @(posedge clk_i);
        #1;
        check("mask after async reset", data_o, 16'h0000);
        check("irq after async reset", {15'd0, irq_o}, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/irqctl.md
IRQCTL -- requirements
Module: irqctl

Interface
REQ-001 SHALL have parameter: N_SRC, 8, number of interrupt sources (1..16).
REQ-002 SHALL have port: clk_i  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rstn_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: irq_src_i  input  N_SRC  interrupt requests from peripherals (e.g. irqck irq_o), synchronous to clk_i.
REQ-005 SHALL have port: sel_i  input  1  uC bus select.
REQ-006 SHALL have port: read_i  input  1  uC read strobe.
REQ-007 SHALL have port: write_i  input  1  uC write strobe.
REQ-008 SHALL have port: addr_i  input  2  register address.
REQ-009 SHALL have port: data_i  input  16  write data.
REQ-010 SHALL have port: data_o  output  16  read data.
REQ-011 SHALL have port: irq_o  output  1  registered interrupt request to CPU.

Function
REQ-012 SHALL map registers: 00 PEND (R, W1C), 01 MASK (RW), 10 VEC (R = acknowledge, W = end-of-interrupt), 11 EDGE (RW); bits >= N_SRC read 0, ignore writes.
REQ-013 SHALL register addr_i on read_i & sel_i; data_o combinationally decodes the registered address, so read data is valid the cycle after the strobe.
REQ-014 SHALL read VEC as {bit15 = in-service, bits[3:0] = vector_q, other bits 0}.
REQ-015 SHALL, for level source i, load PEND[i] <= irq_src_i[i] every cycle; W1C ignored.
REQ-016 SHALL, for edge source i, set PEND[i] on irq_src_i[i] & ~src_q[i] (one-cycle-delayed copy); clear by writing 1 to PEND[i]; simultaneous set and clear leaves bit set.
REQ-017 SHALL define active = PEND & MASK; priority fixed, lowest index highest.
REQ-018 SHALL implement FSM IDLE, REQ, SERVICE; irq_o = 1 exactly while in REQ.
REQ-019 SHALL transition IDLE -> REQ when active != 0; irq_o rises one cycle after active becomes nonzero.
REQ-020 SHALL transition REQ -> IDLE when active == 0 (source withdrawn or masked) before acknowledge.
REQ-021 SHALL, on read strobe to VEC in REQ with active != 0, latch vector_q = highest-priority active index, clear its PEND bit if edge, and enter SERVICE.
REQ-022 SHALL, on read strobe to VEC in REQ with active == 0 in that cycle, go IDLE and leave vector_q unchanged.
REQ-023 SHALL make VEC reads in IDLE or SERVICE side-effect-free.
REQ-024 SHALL transition SERVICE -> IDLE on any write to VEC; VEC writes in IDLE or REQ are ignored.
REQ-025 SHALL ignore new requests in SERVICE (no nesting); they remain pending and raise irq_o after EOI.

Reset
REQ-026 SHALL, on rstn_i low, asynchronously clear PEND, MASK, EDGE, src_q, vector_q, addr_q, and set state IDLE; irq_o = 0, data_o = 0.
REQ-027 SHALL abandon any in-progress request or service on reset; no EOI is needed afterward.

Configuration
REQ-028 SHALL support macro IRQCTL_EDGE_EN: defined -> EDGE register and edge detection per REQ-016; undefined -> all sources level, EDGE reads 0, writes ignored, src_q removed.

Verification
REQ-029 SHALL cover: MASK=0x0004, irq_src_i[2] held 1 -> irq_o=1 one cycle after PEND[2]; VEC read -> 0x8002, irq_o=0; EOI write -> IDLE, irq_o=1 again while source held.
REQ-030 SHALL cover: MASK=0x00FF, sources 5 and 3 high together -> VEC read returns 0x8003.
REQ-031 SHALL cover (EDGE_EN): EDGE=0x0001, one-cycle pulse on src 0 -> PEND=0x0001 persists; VEC read clears PEND[0]; W1C in same cycle as new edge -> PEND[0] stays 1.
REQ-032 SHALL cover: in REQ, MASK written 0 -> irq_o=0 next cycle, state IDLE; VEC reads 0x0000.
REQ-033 SHALL cover: in SERVICE, source 1 rises -> irq_o stays 0 until EOI, then asserts; VEC read in SERVICE leaves vector unchanged.
REQ-034 SHALL cover: rstn_i low mid-SERVICE -> all registers 0, irq_o=0 immediately; without IRQCTL_EDGE_EN, EDGE write 0xFFFF reads back 0x0000.
